// File: rtl/gpio_input_filter_if.sv
// CPU register-bus bundle for gpio_input_filter.
// The master drives address, write data and the two strobes; the slave returns
// registered read data on dout.
interface gpio_input_filter_if;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       wr_en;
    logic       rd_en;

    modport master (
        output addr,
        output din,
        output wr_en,
        output rd_en,
        input  dout
    );

    modport slave (
        input  addr,
        input  din,
        input  wr_en,
        input  rd_en,
        output dout
    );
endinterface

// File: rtl/gpio_input_filter.sv
// gpio_input_filter: 8-bit GPIO input debouncer with CPU register access.
// Each pin goes through a 2-flop synchronizer, then a per-bit qualification
// counter.  A new level is accepted only after it has been seen for P+1
// consecutive cycles at the synchronizer output.
// Registers: 0 FCFG (period P), 1 FVAL (filtered levels, RO),
//            2 EDGE (sticky change flags, W1C), 3 EMASK (interrupt mask).
// Optional feature macro: GPIO_FILT_IRQ_EN adds the EMASK register and the irq
// output.  Without it EMASK reads 8'h00 and writes to it are dropped.
module gpio_input_filter #(
    parameter int ADDR_LSB          = 0,
    parameter int OPT_MEM_ADDR_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    gpio_input_filter_if.slave   bus,
    input  logic [7:0]           pin_in,
    output logic [7:0]           pin_filt
`ifdef GPIO_FILT_IRQ_EN
    ,
    output logic                 irq
`endif
);

    localparam int SEL_W = OPT_MEM_ADDR_BITS + 1;
    localparam logic [SEL_W-1:0] SEL_FCFG  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_FVAL  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_EDGE  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_EMASK = SEL_W'(3);

    logic [SEL_W-1:0] sel;
    logic             wr_fcfg;
    logic             wr_edge;
    logic             rd_go;

    logic [7:0] s1_reg;
    logic [7:0] s2_reg;
    logic [7:0] filt_reg;
    logic [7:0] p_reg;
    logic [7:0] edge_reg;
    logic [7:0] edge_next;
    logic [7:0] dout_reg;
    logic [7:0] emask_val;
    logic [7:0] rd_data;
    logic [7:0] upd;
    logic [7:0] cnt_reg  [8];
    logic [7:0] cnt_next [8];

    // Upper address bits are decoded outside this block.
    logic unused_addr;
    assign unused_addr = ^bus.addr;

    assign sel     = bus.addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
    assign wr_fcfg = bus.wr_en && (sel == SEL_FCFG);
    assign wr_edge = bus.wr_en && (sel == SEL_EDGE);
    // A simultaneous write wins; the read is dropped and dout holds.
    assign rd_go   = bus.rd_en && !bus.wr_en;

    // Per-bit qualification.  A write to FCFG restarts every counter and
    // blocks acceptance for that one cycle so the new period starts clean.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            logic match;
            logic hit;
            assign match        = (s2_reg[gi] == filt_reg[gi]);
            assign hit          = (cnt_reg[gi] == p_reg);
            assign upd[gi]      = !match && hit && !wr_fcfg;
            assign cnt_next[gi] = (wr_fcfg || match || hit) ? 8'd0
                                                            : cnt_reg[gi] + 8'd1;
        end
    endgenerate

    // Clear-on-write first, then OR in new edges so a coincident set survives.
    assign edge_next = (edge_reg & ~(wr_edge ? bus.din : 8'h00)) | upd;

    // Synchronizer, filter state, counters, period and sticky edge flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg   <= 8'h00;
            s2_reg   <= 8'h00;
            filt_reg <= 8'h00;
            p_reg    <= 8'h04;
            edge_reg <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt_reg[i] <= 8'd0;
            end
        end else begin
            s1_reg   <= pin_in;
            s2_reg   <= s1_reg;
            filt_reg <= filt_reg ^ upd;
            edge_reg <= edge_next;
            if (wr_fcfg) begin
                p_reg <= bus.din;
            end
            for (int i = 0; i < 8; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

`ifdef GPIO_FILT_IRQ_EN
    logic [7:0] emask_reg;
    logic       irq_reg;
    logic       wr_emask;

    assign wr_emask  = bus.wr_en && (sel == SEL_EMASK);
    assign emask_val = emask_reg;
    assign irq       = irq_reg;

    // Interrupt mask register and registered level interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            emask_reg <= 8'h00;
            irq_reg   <= 1'b0;
        end else begin
            if (wr_emask) begin
                emask_reg <= bus.din;
            end
            irq_reg <= |(edge_reg & emask_reg);
        end
    end
`else
    assign emask_val = 8'h00;
`endif

    // Read-data select.
    always_comb begin
        rd_data = 8'h00;
        case (sel)
            SEL_FCFG:  rd_data = p_reg;
            SEL_FVAL:  rd_data = filt_reg;
            SEL_EDGE:  rd_data = edge_reg;
            SEL_EMASK: rd_data = emask_val;
            default:   rd_data = 8'h00;
        endcase
    end

    // Registered read port; holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_reg <= 8'h00;
        end else if (rd_go) begin
            dout_reg <= rd_data;
        end
    end

    assign bus.dout = dout_reg;
    assign pin_filt = filt_reg;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Self-checking bench for gpio_input_filter.  Register reads push their
// expected value onto a scoreboard queue; a monitor pops and compares when
// dout becomes valid.  Pin-path timing is checked cycle-exactly.
module tb_gpio_input_filter;

    localparam logic [7:0] A_FCFG  = 8'h00;
    localparam logic [7:0] A_FVAL  = 8'h01;
    localparam logic [7:0] A_EDGE  = 8'h02;
    localparam logic [7:0] A_EMASK = 8'h03;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pin_in;
    logic [7:0] pin_filt;
    logic [7:0] pins_v;
`ifdef GPIO_FILT_IRQ_EN
    logic       irq;
`endif

    gpio_input_filter_if bus ();

    gpio_input_filter dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .pin_in   (pin_in),
        .pin_filt (pin_filt)
`ifdef GPIO_FILT_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q [$];
    string      tag_q [$];
    logic       rd_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    // A read accepted at this edge makes dout valid right after it.
    always @(posedge clk) begin
        rd_seen <= bus.rd_en && !bus.wr_en && !reset;
    end

    // Scoreboard: compare dout against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check(tag_q.pop_front(), {24'h0, bus.dout}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pins(input logic [7:0] v);
        pins_v = v;
        pin_in = v;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.din   = d;
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        int  plen [3];
        bit  pexp [3];
        bit  saw;
        bit  irq_seen;
        logic [7:0] emask_exp;

        plen = '{1, 4, 5};
        pexp = '{1'b0, 1'b0, 1'b1};
        reset = 1'b1;
        bus.addr = 8'h00;
        bus.din = 8'h00;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        set_pins(8'h00);
        cyc(3);
        reset = 1'b0;

        // Reset values.
        check("rst_pin_filt", {24'h0, pin_filt}, 32'h00);
        check("rst_dout", {24'h0, bus.dout}, 32'h00);
        rd(A_FCFG,  8'h04, "rst_fcfg");
        rd(A_FVAL,  8'h00, "rst_fval");
        rd(A_EDGE,  8'h00, "rst_edge");
        rd(A_EMASK, 8'h00, "rst_emask");

        // P=4: pin 0 rises, accepted on the 7th edge.
        set_pins(8'h01);
        cyc(6);
        check("p0_before7", {31'h0, pin_filt[0]}, 32'd0);
        cyc(1);
        check("p0_at7", {31'h0, pin_filt[0]}, 32'd1);
        rd(A_EDGE, 8'h01, "p0_edge");
        rd(A_FVAL, 8'h01, "p0_fval");
        wr(A_EDGE, 8'h01);
        rd(A_EDGE, 8'h00, "p0_edge_clr");

        // Pin 3 pulses of 1, 4 and 5 cycles.
        for (int k = 0; k < 3; k++) begin
            saw = 1'b0;
            set_pins(pins_v | 8'h08);
            cyc(plen[k]);
            set_pins(pins_v & 8'hF7);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (pin_filt[3]) saw = 1'b1;
            end
            check($sformatf("p3_pulse%0d_seen", plen[k]), {31'h0, saw}, {31'h0, pexp[k]});
            check($sformatf("p3_pulse%0d_final", plen[k]), {24'h0, pin_filt}, 32'h01);
            rd(A_EDGE, pexp[k] ? 8'h08 : 8'h00, $sformatf("p3_pulse%0d_edge", plen[k]));
        end
        wr(A_EDGE, 8'h08);

        // EDGE clear coinciding with a new bit-2 edge: the set wins.
        set_pins(pins_v | 8'h04);
        cyc(6);
        wr(A_EDGE, 8'hFF);
        check("p2_filt", {24'h0, pin_filt}, 32'h05);
        rd(A_EDGE, 8'h04, "p2_edge_set_wins");

        // P=255: full 256-cycle qualification on pin 6.
        wr(A_FCFG, 8'hFF);
        set_pins(pins_v | 8'h40);
        cyc(257);
        check("p6_before258", {31'h0, pin_filt[6]}, 32'd0);
        cyc(1);
        check("p6_at258", {31'h0, pin_filt[6]}, 32'd1);

        // Pin 7 mid-count, then FCFG=2 restarts the counter.
        set_pins(pins_v | 8'h80);
        cyc(200);
        check("p7_pending", {31'h0, pin_filt[7]}, 32'd0);
        wr(A_FCFG, 8'h02);
        cyc(2);
        check("p7_wr_plus2", {31'h0, pin_filt[7]}, 32'd0);
        cyc(1);
        check("p7_wr_plus3", {31'h0, pin_filt[7]}, 32'd1);
        rd(A_FCFG, 8'h02, "fcfg_02");
        rd(A_EDGE, 8'hC4, "edge_c4");
        rd(A_EDGE, 8'hC4, "edge_read_no_clear");

        // FVAL is read-only.
        wr(A_FVAL, 8'h00);
        rd(A_FVAL, 8'hC5, "fval_ro");

        // Simultaneous write and read: write happens, dout holds.
        bus.addr  = A_FCFG;
        bus.din   = 8'h03;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("wr_rd_dout_hold", {24'h0, bus.dout}, 32'hC5);
        rd(A_FCFG, 8'h03, "wr_rd_fcfg");

        // Mask register.
`ifdef GPIO_FILT_IRQ_EN
        emask_exp = 8'h10;
`else
        emask_exp = 8'h00;
`endif
        wr(A_EMASK, 8'h10);
        rd(A_EMASK, emask_exp, "emask");

`ifdef GPIO_FILT_IRQ_EN
        // P=3: edge on pin 4 lands at edge 6, irq at edge 7.
        check("irq_idle", {31'h0, irq}, 32'd0);
        set_pins(pins_v | 8'h10);
        cyc(6);
        check("irq_p4_before", {31'h0, irq}, 32'd0);
        check("p4_filt", {31'h0, pin_filt[4]}, 32'd1);
        cyc(1);
        check("irq_p4_set", {31'h0, irq}, 32'd1);
        wr(A_EDGE, 8'h10);
        check("irq_clr_same", {31'h0, irq}, 32'd1);
        cyc(1);
        check("irq_clr_next", {31'h0, irq}, 32'd0);
        irq_seen = 1'b0;
        set_pins(pins_v | 8'h20);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (irq) irq_seen = 1'b1;
        end
        check("irq_p5_masked", {31'h0, irq_seen}, 32'd0);
        check("p5_filt", {31'h0, pin_filt[5]}, 32'd1);
`else
        irq_seen = 1'b0;
        check("irq_absent", {31'h0, irq_seen}, 32'd0);
`endif

        // Reset with a pending write and pins held high through it.
        reset     = 1'b1;
        bus.addr  = A_FCFG;
        bus.din   = 8'h09;
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        cyc(2);
        check("rst2_pin_filt", {24'h0, pin_filt}, 32'h00);
        reset = 1'b0;
        cyc(6);
        check("rst2_before7", {24'h0, pin_filt}, 32'h00);
        cyc(1);
        check("rst2_at7", {24'h0, pin_filt}, {24'h0, pins_v});
        rd(A_FCFG,  8'h04, "rst2_fcfg");
        rd(A_EDGE,  pins_v, "rst2_edge");
        rd(A_EMASK, 8'h00, "rst2_emask");
`ifdef GPIO_FILT_IRQ_EN
        check("rst2_irq", {31'h0, irq}, 32'd0);
`endif

        cyc(2);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
